// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared FSM encoding and MEM/WB record for the MEM stage
package mem_stage_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0] wn;
    logic misalign;
    logic err;
  } mem_wb_t;
  localparam mem_wb_t BUBBLE = '0;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: variable-latency data-memory req/ack bus
interface mem_stage_ctrl_if #(parameter int ADDR_W = 32);
  logic dm_req;
  logic dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic dm_ack;
  modport master(output dm_req, dm_we, dm_addr, dm_wdata, input dm_rdata, dm_ack);
  modport slave(input dm_req, dm_we, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register, loads a bubble when bubble is high
module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= BUBBLE;
    else q <= bubble ? BUBBLE : d;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage FSM issuing loads/stores with stall, timeout and MEM/WB write-back
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic MemRead_in,
  input  logic MemWrite_in,
  input  logic RegWrite_in,
  input  logic MemtoReg_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] RD2_in,
  input  logic [4:0] WN_in,
  output logic stall,
  mem_stage_ctrl_if.master bus,
  output logic RegWrite_out,
  output logic MemtoReg_out,
  output logic [31:0] RDATA_out,
  output logic [31:0] ALU_out,
  output logic [4:0] WN_out,
  output logic misalign_out,
  output logic err_out
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic mem_op, aligned, idle, timeout;
  mem_wb_t d, q;
  assign mem_op = MemRead_in | MemWrite_in;
  assign aligned = ALU_in[1:0] == 2'b00;
  assign idle = state == IDLE;
  assign timeout = !idle && cnt == LAST;
  assign stall = idle ? mem_op && aligned : !bus.dm_ack && !timeout;
  // Outside a bubble, WAIT without ack can only mean the timeout abort
  assign d = '{
    reg_write: RegWrite_in && !(idle ? mem_op : !bus.dm_ack),
    mem_to_reg: MemtoReg_in,
    rdata: (!idle && bus.dm_ack && !bus.dm_we) ? bus.dm_rdata : 32'd0,
    alu: ALU_in,
    wn: WN_in,
    misalign: idle && mem_op && !aligned,
    err: !idle && !bus.dm_ack
  };
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.dm_req <= 1'b0;
      bus.dm_we <= 1'b0;
      bus.dm_addr <= '0;
      bus.dm_wdata <= '0;
    end else if (idle) begin
      if (mem_op && aligned) begin
        state <= WAIT;
        cnt <= '0;
        bus.dm_req <= 1'b1;
        bus.dm_we <= MemWrite_in;
        bus.dm_addr <= ALU_in[ADDR_W-1:0];
        bus.dm_wdata <= RD2_in;
      end
    end else if (bus.dm_ack || timeout) begin
      state <= IDLE;
      bus.dm_req <= 1'b0;
    end else cnt <= cnt + 1'b1;
  mem_wb_reg u_mem_wb (.clk(clk), .rst(rst), .bubble(stall), .d(d), .q(q));
  assign RegWrite_out = q.reg_write;
  assign MemtoReg_out = q.mem_to_reg;
  assign RDATA_out = q.rdata;
  assign ALU_out = q.alu;
  assign WN_out = q.wn;
  assign misalign_out = q.misalign;
  assign err_out = q.err;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and random checks of mem_stage_ctrl against a transaction-level model
module tb_mem_stage_ctrl;
  localparam int TO = 16;
  logic clk = 0, rst = 0;
  logic rd = 0, wr = 0, rw = 0, m2r = 0;
  logic [31:0] alu = 0, rd2 = 0;
  logic [4:0] wn = 0;
  logic stall, rw_o, m2r_o, mis_o, err_o;
  logic [31:0] rdata_o, alu_o;
  logic [4:0] wn_o;
  int total = 0, bad = 0;
  mem_stage_ctrl_if #(.ADDR_W(32)) bus ();
  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemRead_in(rd), .MemWrite_in(wr), .RegWrite_in(rw),
    .MemtoReg_in(m2r), .ALU_in(alu), .RD2_in(rd2), .WN_in(wn), .stall(stall), .bus(bus),
    .RegWrite_out(rw_o), .MemtoReg_out(m2r_o), .RDATA_out(rdata_o), .ALU_out(alu_o),
    .WN_out(wn_o), .misalign_out(mis_o), .err_out(err_o)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $error("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_wb(input string tag, input logic e_rw, e_m2r, input logic [31:0] e_rd, e_alu,
                        input logic [4:0] e_wn, input logic e_mis, e_err);
    chk({tag, ".rw"}, {31'd0, rw_o}, {31'd0, e_rw});
    chk({tag, ".m2r"}, {31'd0, m2r_o}, {31'd0, e_m2r});
    chk({tag, ".rdata"}, rdata_o, e_rd);
    chk({tag, ".alu"}, alu_o, e_alu);
    chk({tag, ".wn"}, {27'd0, wn_o}, {27'd0, e_wn});
    chk({tag, ".mis"}, {31'd0, mis_o}, {31'd0, e_mis});
    chk({tag, ".err"}, {31'd0, err_o}, {31'd0, e_err});
  endtask
  // lat = WAIT cycle (1-based) on which memory acks; 0 or >TO means it never answers
  task automatic do_instr(input string tag, input logic i_rd, i_wr, i_rw, i_m2r,
                          input logic [31:0] i_alu, i_rd2, input logic [4:0] i_wn,
                          input int lat, input logic [31:0] mdata, input logic stray);
    logic mem = i_rd | i_wr;
    logic al = i_alu[1:0] == 2'b00;
    rd = i_rd; wr = i_wr; rw = i_rw; m2r = i_m2r; alu = i_alu; rd2 = i_rd2; wn = i_wn;
    if (!mem || !al) begin
      bus.dm_ack = stray;
      bus.dm_rdata = $urandom;
      #1;
      chk({tag, ".stall0"}, {31'd0, stall}, 0);
      chk({tag, ".req0"}, {31'd0, bus.dm_req}, 0);
      @(negedge clk);
      bus.dm_ack = 0;
      #1;
      chk_wb({tag, ".wb"}, i_rw && !mem, i_m2r, 0, i_alu, i_wn, mem, 0);
      chk({tag, ".req1"}, {31'd0, bus.dm_req}, 0);
      return;
    end
    #1;
    chk({tag, ".stall_issue"}, {31'd0, stall}, 1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k == lat) begin
        bus.dm_ack = 1;
        bus.dm_rdata = mdata;
      end
      #1;
      chk({tag, ".req"}, {31'd0, bus.dm_req}, 1);
      chk({tag, ".we"}, {31'd0, bus.dm_we}, {31'd0, i_wr});
      chk({tag, ".addr"}, bus.dm_addr, i_alu);
      chk({tag, ".wdata"}, bus.dm_wdata, i_rd2);
      chk_wb({tag, ".bub"}, 0, 0, 0, 0, 0, 0, 0);
      if (k == lat || k == TO) begin
        chk({tag, ".stall_done"}, {31'd0, stall}, 0);
        @(negedge clk);
        bus.dm_ack = 0;
        #1;
        if (k == lat) chk_wb({tag, ".done"}, i_rw, i_m2r, i_wr ? 32'd0 : mdata, i_alu, i_wn, 0, 0);
        else chk_wb({tag, ".tmo"}, 0, i_m2r, 0, i_alu, i_wn, 0, 1);
        chk({tag, ".req_drop"}, {31'd0, bus.dm_req}, 0);
        return;
      end
      chk({tag, ".stall_wait"}, {31'd0, stall}, 1);
    end
  endtask
  initial begin
    bus.dm_ack = 0;
    bus.dm_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_wb("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.req", {31'd0, bus.dm_req}, 0);
    chk("reset.addr", bus.dm_addr, 0);
    chk("reset.wdata", bus.dm_wdata, 0);
    @(negedge clk);
    rst = 1;
    do_instr("nop", 0, 0, 1, 0, 32'h0000_00A5, 0, 7, 0, 0, 0);
    do_instr("load3", 1, 0, 1, 1, 32'h40, 0, 9, 3, 32'hDEAD_BEEF, 0);
    do_instr("store1", 0, 1, 0, 0, 32'h80, 32'h1234_5678, 0, 1, 32'h5555_AAAA, 0);
    do_instr("misal", 1, 0, 1, 1, 32'h41, 0, 4, 0, 0, 1);
    do_instr("tmo", 1, 0, 1, 1, 32'h44, 0, 5, 0, 0, 0);
    do_instr("ack16", 1, 0, 1, 1, 32'h48, 0, 6, TO, 32'hCAFE_F00D, 0);
    do_instr("both", 1, 1, 1, 0, 32'h4C, 32'hABCD_0123, 2, 2, 32'h1111_2222, 0);
    do_instr("stray", 0, 0, 1, 1, 32'h7, 0, 31, 0, 0, 1);
    rd = 1; wr = 0; rw = 1; m2r = 1; alu = 32'h100; rd2 = 0; wn = 8;
    repeat (3) @(negedge clk);
    rd = 0; alu = 32'h5; wn = 3; m2r = 0;
    #2 rst = 0;
    #1;
    chk_wb("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid.req", {31'd0, bus.dm_req}, 0);
    chk("rst_mid.stall", {31'd0, stall}, 0);
    @(negedge clk);
    rst = 1;
    bus.dm_ack = 1;
    bus.dm_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_ack.stall", {31'd0, stall}, 0);
    @(negedge clk);
    bus.dm_ack = 0;
    #1;
    chk_wb("late_ack", 1, 0, 0, 32'h5, 3, 0, 0);
    chk("late_ack.req", {31'd0, bus.dm_req}, 0);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      do_instr("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, $urandom,
               5'($urandom), $urandom_range(1, TO + 4), $urandom, 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage controller that sits directly downstream of the EX/MEM pipeline register and drives the MEM/WB pipeline register. It issues data-memory loads and stores over a variable-latency req/ack interface. While an access is outstanding it stalls the upstream pipeline. It registers the completed result, with the original control bits, toward write-back.

Parameters:
ADDR_W, 32, data-memory address width; dm_addr = ALU_in[ADDR_W-1:0]
TIMEOUT, 16, max cycles in WAIT without dm_ack before abort (>=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
MemRead_in  in  1  load request from EX/MEM
MemWrite_in  in  1  store request from EX/MEM
RegWrite_in  in  1  register write-back enable from EX/MEM
MemtoReg_in  in  1  write-back select from EX/MEM
ALU_in  in  32  ALU result / effective address
RD2_in  in  32  store data
WN_in  in  5  destination register number
stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle (combinational)
dm_req  out  1  memory request, registered
dm_we  out  1  1 = store, 0 = load; valid while dm_req
dm_addr  out  ADDR_W  word address, latched
dm_wdata  out  32  store data, latched
dm_rdata  in  32  load data; valid with dm_ack
dm_ack  in  1  single-cycle completion strobe
RegWrite_out  out  1  MEM/WB write-back enable
MemtoReg_out  out  1  MEM/WB write-back select
RDATA_out  out  32  load data to WB
ALU_out  out  32  ALU result to WB
WN_out  out  5  destination register to WB
misalign_out  out  1  instruction in MEM/WB had an unaligned access
err_out  out  1  instruction in MEM/WB timed out

Behaviour:
- Reset (rst=0, async): state=IDLE, timeout counter=0, all outputs 0 (dm_req, dm_we, dm_addr, dm_wdata, all MEM/WB fields, flags).
- mem_op = MemRead_in | MemWrite_in. If both are set, it is a store (MemWrite wins).
- aligned = (ALU_in[1:0]==2'b00).
- IDLE, no mem_op:
  - stall=0.
  - At the edge, MEM/WB loads RegWrite/MemtoReg/ALU/WN from the inputs, RDATA_out=0 and flags=0.
  - Latency is 1 cycle.
- IDLE, mem_op and not aligned:
  - No request is issued and stall=0.
  - MEM/WB loads the instruction with RegWrite_out forced 0 and misalign_out=1 (one-cycle pulse).
- IDLE, mem_op and aligned:
  - stall=1.
  - At the edge: go to WAIT; dm_req<=1; dm_we<=MemWrite_in; latch dm_addr and dm_wdata from the inputs; counter<=0.
  - MEM/WB loads a bubble (all fields 0).
- WAIT, dm_ack=0:
  - stall=1, dm_req/dm_addr/dm_wdata held stable, counter+1, MEM/WB loads a bubble.
  - When the counter reaches TIMEOUT-1: drop dm_req and return to IDLE with stall=0 that cycle. MEM/WB loads the instruction with RegWrite_out=0 and err_out=1.
- WAIT, dm_ack=1:
  - stall=0, so upstream advances at this edge.
  - At the edge: dm_req<=0, state<=IDLE.
  - MEM/WB loads the instruction fields. For a load, RDATA_out<=dm_rdata; for a store, RDATA_out<=0.
  - Minimum load/store latency is 2 cycles (ack on the first WAIT cycle).
- An ack arriving in the same cycle as the timeout takes priority over the timeout.
- dm_ack in IDLE is ignored and has no effect.
- There is never more than one outstanding request. dm_req drops for at least one cycle between back-to-back accesses.
- Reset asserted mid-WAIT abandons the transaction. A late dm_ack after reset is ignored.
- Counter width is $clog2(TIMEOUT) bits.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, WAIT=1'b1) and the MEM/WB bubble constant.
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register. It has async active-low reset and a load-bubble select input. mem_stage_ctrl holds the FSM, the timeout counter and the request latches.

Test Plan:
- Non-memory op: RegWrite_in=1, ALU_in=32'h0000_00A5, WN_in=7 → no stall, and the next cycle shows RegWrite_out=1, ALU_out=32'hA5, WN_out=7, RDATA_out=0.
- Load with ack 3 cycles after request: ALU_in=32'h40, memory returns 32'hDEAD_BEEF.
  - stall is high for 3 cycles; dm_addr=32'h40 and dm_we=0 stay stable.
  - Then RDATA_out=32'hDEADBEEF, MemtoReg_out=1, and the cycles before it are bubbles.
- Store with immediate ack: MemWrite_in=1, ALU_in=32'h80, RD2_in=32'h1234_5678 → dm_we=1, dm_wdata=32'h12345678, stall for exactly 1 cycle, RegWrite_out=0.
- Misaligned load at ALU_in=32'h41 → dm_req never asserts, no stall, misalign_out=1 and RegWrite_out=0 for one cycle.
- No ack with TIMEOUT=16 → dm_req high for exactly 16 cycles, then err_out=1 for one cycle and the pipeline resumes. An ack on the 16th WAIT cycle completes normally instead.
- Assert rst low during WAIT, then send a stray dm_ack after release → all outputs 0 immediately, state IDLE, and the stray ack produces no write-back.
